// File: rtl/msg_sched_stream.sv
// msg_sched_stream: SHA-2 message-schedule generator.
// Loads one 16-word padded block and streams W[0..ROUNDS-1], one word per
// w_valid/w_ready handshake. WORD_W selects SHA-256 (32) or SHA-512 (64) sigmas.
// Optional build macro: SCHED_ERR_EN adds the sticky proto_err output.
module msg_sched_stream #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ROUNDS = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      blk_valid,
    output logic                      blk_ready,
    input  logic [16*WORD_W-1:0]      blk_data,
    output logic                      w_valid,
    input  logic                      w_ready,
    output logic [WORD_W-1:0]         w_data,
    output logic [$clog2(ROUNDS)-1:0] w_index,
    output logic                      w_last,
    output logic                      done
`ifdef SCHED_ERR_EN
    ,
    output logic                      proto_err
`endif
);

    localparam int unsigned IDX_W    = $clog2(ROUNDS);
    localparam int unsigned LAST_IDX = ROUNDS - 1;

    // Rotation/shift amounts for the small sigma functions of each word size
    localparam int unsigned S0_R1 = (WORD_W == 64) ? 1  : 7;
    localparam int unsigned S0_R2 = (WORD_W == 64) ? 8  : 18;
    localparam int unsigned S0_SH = (WORD_W == 64) ? 7  : 3;
    localparam int unsigned S1_R1 = (WORD_W == 64) ? 19 : 17;
    localparam int unsigned S1_R2 = (WORD_W == 64) ? 61 : 19;
    localparam int unsigned S1_SH = (WORD_W == 64) ? 6  : 10;

    // Reject unsupported configurations at elaboration
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $error("msg_sched_stream: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 16) begin : g_bad_rounds
        $error("msg_sched_stream: ROUNDS must be at least 16");
    end

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   win [16];
    logic [WORD_W-1:0]   new_word;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
    endfunction

    // Next schedule word: W[t+16] from the window holding W[t..t+15]
    always_comb begin
        new_word = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    end

    // A block can only be taken while idle and out of reset
    assign blk_ready = (state == S_IDLE) && !reset;

    // The presented word is always the head of the window
    assign w_data = win[0];

    // Control FSM and sliding window
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            w_valid <= 1'b0;
            w_index <= '0;
            w_last  <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            win[i] <= blk_data[WORD_W*(15-i) +: WORD_W];
                        end
                        w_index <= '0;
                        w_last  <= 1'b0;
                        w_valid <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_ready) begin
                        for (int i = 0; i < 15; i++) begin
                            win[i] <= win[i+1];
                        end
                        win[15] <= new_word;
                        if (w_index == IDX_W'(LAST_IDX)) begin
                            state   <= S_IDLE;
                            w_valid <= 1'b0;
                            w_index <= '0;
                            w_last  <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            w_index <= w_index + IDX_W'(1);
                            w_last  <= (w_index == IDX_W'(LAST_IDX - 1));
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SCHED_ERR_EN
    logic              stall_q;
    logic [WORD_W-1:0] stall_data_q;
    logic              pend_q;

    // Sticky protocol monitor: unstable stalled data or a withdrawn block offer
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q      <= 1'b0;
            stall_data_q <= '0;
            pend_q       <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            stall_q      <= (state == S_RUN) && w_valid && !w_ready;
            stall_data_q <= w_data;
            pend_q       <= blk_valid && !blk_ready;
            if ((stall_q && (state == S_RUN) && (w_data != stall_data_q)) ||
                (pend_q && !blk_valid && !blk_ready)) begin
                proto_err <= 1'b1;
            end
        end
    end
`endif

endmodule
